// File: rtl/mult_seq_ctrl.sv
// Sequencing controller for a bit-serial multiplier datapath: takes an operand
// pair, clears/loads the datapath, streams A LSB-first and gathers the product.
module mult_seq_ctrl #(
  parameter int N   = 8,
  parameter int M   = 8,
  parameter int LAT = 0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [N-1:0]     in_a,
  input  logic [M-1:0]     in_x,
  output logic             mult_rst,
  output logic [M-1:0]     mult_x,
  output logic             mult_a,
  input  logic             mult_ax,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [N+M-1:0]   out_p,
  output logic             busy
);

  localparam int P  = N + M;
  localparam int CW = $clog2(P + LAT) + 1;
  localparam logic [CW-1:0] N_C    = CW'(N);
  localparam logic [CW-1:0] LAST_C = CW'(P + LAT - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    RUN  = 2'd2,
    DONE = 2'd3
  } state_t;

  state_t          state;
  state_t          state_nx;
  logic [CW-1:0]   cnt;
  logic [N-1:0]    a_reg;
  logic [M-1:0]    x_reg;
  logic [P-1:0]    p_reg;
  logic [N-1:0]    a_sel;
  logic            in_ready_r;
  logic            out_valid_r;
  logic            busy_r;
  logic            capture;

  // Product bits only become valid once the datapath latency has elapsed.
  generate
    if (LAT == 0) begin : g_cap_now
      assign capture = 1'b1;
    end else begin : g_cap_late
      assign capture = (cnt >= CW'(LAT));
    end
  endgenerate

  // Next-state logic.
  always_comb begin
    state_nx = state;
    case (state)
      IDLE: begin
        if (in_valid) state_nx = LOAD;
        else          state_nx = IDLE;
      end
      LOAD: state_nx = RUN;
      RUN: begin
        if (cnt == LAST_C) state_nx = DONE;
        else               state_nx = RUN;
      end
      DONE: begin
        if (out_ready) state_nx = IDLE;
        else           state_nx = DONE;
      end
      default: state_nx = IDLE;
    endcase
  end

  // Serial A bit: zero outside RUN and past N so the carries flush.
  always_comb begin
    a_sel  = a_reg >> cnt;
    mult_a = 1'b0;
    if (state == RUN && cnt < N_C) mult_a = a_sel[0];
    else                           mult_a = 1'b0;
  end

  // State, operand/product registers and registered handshake flags.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state       <= IDLE;
      cnt         <= '0;
      a_reg       <= '0;
      x_reg       <= '0;
      p_reg       <= '0;
      in_ready_r  <= 1'b1;
      out_valid_r <= 1'b0;
      busy_r      <= 1'b0;
    end else begin
      state       <= state_nx;
      in_ready_r  <= (state_nx == IDLE);
      out_valid_r <= (state_nx == DONE);
      busy_r      <= (state_nx != IDLE);
      case (state)
        IDLE: begin
          if (in_valid) begin
            a_reg <= in_a;
            x_reg <= in_x;
            p_reg <= '0;
            cnt   <= '0;
          end
        end
        LOAD: cnt <= '0;
        RUN: begin
          cnt <= cnt + CW'(1);
          if (capture) p_reg <= {mult_ax, p_reg[P-1:1]};
        end
        DONE: cnt <= cnt;
        default: cnt <= '0;
      endcase
    end
  end

  // The datapath is held cleared while this controller is in reset.
  assign mult_rst  = ~rst | (state == LOAD);
  assign mult_x    = x_reg;
  assign out_p     = p_reg;
  assign in_ready  = in_ready_r & rst;
  assign out_valid = out_valid_r;
  assign busy      = busy_r;

endmodule

// File: tb/tb_mult_seq_ctrl.sv
// Self-checking bench: two controllers (LAT=0 and LAT=2), each driving a
// behavioural serial-multiplier model; products compared against a*x.
module tb_mult_seq_ctrl;

  logic        clk;
  logic        rst       [2];
  logic        in_valid  [2];
  logic        in_ready  [2];
  logic [7:0]  in_a      [2];
  logic [7:0]  in_x      [2];
  logic        mult_rst  [2];
  logic [7:0]  mult_x    [2];
  logic        mult_a    [2];
  logic        mult_ax   [2];
  logic        out_valid [2];
  logic        out_ready [2];
  logic [15:0] out_p     [2];
  logic        busy      [2];

  int          n_checks;
  int          n_fail;

  int          dk   [2];
  int unsigned dacc [2];
  int unsigned dx   [2];

  mult_seq_ctrl #(.N(8), .M(8), .LAT(0)) dut0 (
    .clk(clk), .rst(rst[0]), .in_valid(in_valid[0]), .in_ready(in_ready[0]),
    .in_a(in_a[0]), .in_x(in_x[0]), .mult_rst(mult_rst[0]), .mult_x(mult_x[0]),
    .mult_a(mult_a[0]), .mult_ax(mult_ax[0]), .out_valid(out_valid[0]),
    .out_ready(out_ready[0]), .out_p(out_p[0]), .busy(busy[0])
  );

  mult_seq_ctrl #(.N(8), .M(8), .LAT(2)) dut2 (
    .clk(clk), .rst(rst[1]), .in_valid(in_valid[1]), .in_ready(in_ready[1]),
    .in_a(in_a[1]), .in_x(in_x[1]), .mult_rst(mult_rst[1]), .mult_x(mult_x[1]),
    .mult_a(mult_a[1]), .mult_ax(mult_ax[1]), .out_valid(out_valid[1]),
    .out_ready(out_ready[1]), .out_p(out_p[1]), .busy(busy[1])
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Product bit k-lat of (A bits seen so far) * X: later A bits cannot
  // influence lower product bits, so this equals the true product bit.
  function automatic logic model_bit(input int k, input int unsigned acc,
                                     input logic a, input int unsigned x,
                                     input int lat);
    longint unsigned full;
    longint unsigned prod;
    full = longint'(acc) | (longint'(a) << k);
    prod = full * longint'(x);
    if (k < lat) return 1'b0;
    return prod[k - lat];
  endfunction

  assign mult_ax[0] = model_bit(dk[0], dacc[0], mult_a[0], dx[0], 0);
  assign mult_ax[1] = model_bit(dk[1], dacc[1], mult_a[1], dx[1], 2);

  // Datapath model: clear and latch X while mult_rst is high, else accumulate A.
  always @(posedge clk) begin
    for (int i = 0; i < 2; i++) begin
      if (mult_rst[i]) begin
        dk[i]   <= 0;
        dacc[i] <= 0;
        dx[i]   <= 32'(mult_x[i]);
      end else begin
        dacc[i] <= dacc[i] | (32'(mult_a[i]) << dk[i]);
        dk[i]   <= dk[i] + 1;
      end
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // One operation on instance i, starting at a negedge; returns idle wait cycles.
  task automatic do_op(input int i, input logic [7:0] a, input logic [7:0] x,
                       input int stall, input bit keep, output int w);
    int cyc;
    int nrst;
    int bad;
    int lat;
    logic [15:0] expv;
    lat  = (i == 1) ? 2 : 0;
    expv = 16'(a) * 16'(x);
    in_a[i] = a;
    in_x[i] = x;
    in_valid[i]  = 1'b1;
    out_ready[i] = 1'b0;
    w = 0;
    while (!in_ready[i] && w < 50) begin
      @(negedge clk);
      w++;
    end
    chk("accept_bound", 32'(w < 50), 32'd1);
    @(negedge clk);
    if (!keep) in_valid[i] = 1'b0;
    cyc  = 1;
    nrst = 0;
    bad  = 0;
    while (!out_valid[i] && cyc < 60) begin
      if (mult_rst[i]) nrst++;
      if (in_ready[i] || !busy[i]) bad++;
      @(negedge clk);
      cyc++;
    end
    chk("latency", 32'(cyc), 32'(16 + lat + 2));
    chk("mult_rst_pulses", 32'(nrst), 32'd1);
    chk("busy_no_ready", 32'(bad), 32'd0);
    chk("product", 32'(out_p[i]), 32'(expv));
    chk("done_mult_x", 32'(mult_x[i]), 32'(x));
    chk("done_mult_a", 32'(mult_a[i]), 32'd0);
    for (int s = 0; s < stall; s++) begin
      @(negedge clk);
      chk("stall_valid", 32'(out_valid[i]), 32'd1);
      chk("stall_product", 32'(out_p[i]), 32'(expv));
      chk("stall_in_ready", 32'(in_ready[i]), 32'd0);
    end
    out_ready[i] = 1'b1;
    @(negedge clk);
    out_ready[i] = 1'b0;
    chk("post_valid", 32'(out_valid[i]), 32'd0);
    chk("post_in_ready", 32'(in_ready[i]), 32'd1);
    chk("post_busy", 32'(busy[i]), 32'd0);
  endtask

  initial begin
    int w;
    int nv;
    n_checks = 0;
    n_fail   = 0;
    for (int i = 0; i < 2; i++) begin
      rst[i] = 1'b0;
      in_valid[i] = 1'b0;
      out_ready[i] = 1'b0;
      in_a[i] = 8'd0;
      in_x[i] = 8'd0;
    end
    repeat (3) @(negedge clk);
    for (int i = 0; i < 2; i++) begin
      chk("rst_out_valid", 32'(out_valid[i]), 32'd0);
      chk("rst_busy", 32'(busy[i]), 32'd0);
      chk("rst_mult_rst", 32'(mult_rst[i]), 32'd1);
      chk("rst_mult_a", 32'(mult_a[i]), 32'd0);
      chk("rst_out_p", 32'(out_p[i]), 32'd0);
      chk("rst_mult_x", 32'(mult_x[i]), 32'd0);
      rst[i] = 1'b1;
    end
    @(negedge clk);
    for (int i = 0; i < 2; i++) begin
      chk("rel_in_ready", 32'(in_ready[i]), 32'd1);
      chk("rel_mult_rst", 32'(mult_rst[i]), 32'd0);
    end

    // Directed products, including extremes and backpressure.
    do_op(0, 8'd13, 8'd11, 0, 1'b0, w);
    do_op(0, 8'hFF, 8'hFF, 0, 1'b0, w);
    do_op(0, 8'h00, 8'hA5, 0, 1'b0, w);
    do_op(0, 8'd13, 8'd11, 5, 1'b0, w);

    // Back-to-back with in_valid held: second accept right after handshake.
    do_op(0, 8'd3, 8'd5, 0, 1'b1, w);
    do_op(0, 8'd200, 8'd100, 0, 1'b0, w);
    chk("b2b_accept_wait", 32'(w), 32'd0);

    // Abort in RUN at cnt=6 with two reset cycles.
    in_a[0] = 8'd50;
    in_x[0] = 8'd77;
    in_valid[0] = 1'b1;
    @(negedge clk);
    in_valid[0] = 1'b0;
    repeat (7) @(negedge clk);
    chk("mid_busy", 32'(busy[0]), 32'd1);
    chk("mid_mult_rst", 32'(mult_rst[0]), 32'd0);
    rst[0] = 1'b0;
    for (int k = 0; k < 2; k++) begin
      @(negedge clk);
      chk("abort_valid", 32'(out_valid[0]), 32'd0);
      chk("abort_busy", 32'(busy[0]), 32'd0);
      chk("abort_mult_rst", 32'(mult_rst[0]), 32'd1);
    end
    rst[0] = 1'b1;
    nv = 0;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      if (out_valid[0] || busy[0] || mult_rst[0]) nv++;
    end
    chk("abort_quiet", 32'(nv), 32'd0);
    do_op(0, 8'd7, 8'd9, 0, 1'b0, w);

    // Random operands on both latencies.
    for (int k = 0; k < 6; k++)
      do_op(0, 8'($urandom_range(0, 255)), 8'($urandom_range(0, 255)),
            int'($urandom_range(0, 3)), 1'b0, w);
    do_op(1, 8'd13, 8'd11, 0, 1'b0, w);
    do_op(1, 8'hFF, 8'hFF, 2, 1'b0, w);
    for (int k = 0; k < 3; k++)
      do_op(1, 8'($urandom_range(0, 255)), 8'($urandom_range(0, 255)), 0, 1'b0, w);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
